// File: rtl/spram_stream_reader_pkg.sv
// Shared types and constants for the single-port RAM stream reader.
package spram_stream_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_e;

    localparam int RD_LATENCY   = 1;
    localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/spram_stream_reader_if.sv
// Command, RAM-read and output-stream signals of the stream reader.
// Defining SPRAM_RD_LAST_EN adds the out_last stream signal.
interface spram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  done;
`ifdef SPRAM_RD_LAST_EN
    logic                  out_last;
`endif

    modport master (
        input  cmd_valid, cmd_base, cmd_len, mem_gnt, mem_rdata, out_ready,
        output cmd_ready, mem_req, mem_addr, out_valid, out_data, done
`ifdef SPRAM_RD_LAST_EN
        , output out_last
`endif
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, mem_gnt, mem_rdata, out_ready,
        input  cmd_ready, mem_req, mem_addr, out_valid, out_data, done
`ifdef SPRAM_RD_LAST_EN
        , input out_last
`endif
    );
endinterface

// File: rtl/spram_rd_buf.sv
// Two-entry registered FIFO absorbing the RAM read latency; head drives the stream directly.
module spram_rd_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push && pop) begin
            if (count_q == 2'd2) begin
                head_d = tail_q;
                tail_d = din;
            end else begin
                head_d = din;
            end
        end else if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) head_d = din;
            else                 tail_d = din;
            count_d = count_q + 2'd1;
        end
    end

    // NOTE: the entries are plain flops, not a RAM, so they are reset; out_data must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;
endmodule

// File: rtl/spram_stream_reader.sv
// Drains base..base+len-1 (mod DEPTH) of a single-port RAM onto a valid/ready stream.
// Defining SPRAM_RD_LAST_EN adds out_last, marking the final beat of each job.
module spram_stream_reader
    import spram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spram_stream_reader_if.master bus
);
`ifdef SPRAM_RD_LAST_EN
    localparam int BUF_WIDTH = DATA_WIDTH + 1;
`else
    localparam int BUF_WIDTH = DATA_WIDTH;
`endif

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  issued_inc, cmd_len_clamped;
    logic                  inflight_q, inflight_d, done_q, done_d;
    logic [1:0]            buf_count;
    logic [2:0]            occupancy;
    logic [BUF_WIDTH-1:0]  buf_din, buf_head;
    logic                  out_valid, pop, req, issue, cmd_fire, final_beat;

    assign out_valid  = (buf_count != 2'd0);
    assign pop        = out_valid && bus.out_ready;
    assign occupancy  = 3'(buf_count) + (inflight_q ? 3'(RD_LATENCY) : 3'd0);
    // A pop this cycle frees a slot, so a full buffer can still issue without a bubble.
    assign req        = (state_q == RD_RUN) && (issued_q < len_q)
                        && ((occupancy < 3'(RD_BUF_DEPTH)) || pop);
    assign issue      = req && bus.mem_gnt;
    assign issued_inc = issued_q + LEN_WIDTH'(1);
    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    assign final_beat = (state_q == RD_DRAIN) && pop && (buf_count == 2'd1) && !inflight_q;
    assign cmd_len_clamped = (bus.cmd_len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.cmd_len;

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        inflight_d = issue;
        done_d     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RD_RUN;
                        addr_d   = bus.cmd_base;
                        len_d    = cmd_len_clamped;
                        issued_d = '0;
                    end
                end
            end
            RD_RUN: begin
                if (issue) begin
                    issued_d = issued_inc;
                    addr_d   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    if (issued_inc == len_q) state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (final_beat) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

`ifdef SPRAM_RD_LAST_EN
    logic last_inflight_q, last_inflight_d;
    assign last_inflight_d = issue && (issued_inc == len_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_inflight_q <= 1'b0;
        else        last_inflight_q <= last_inflight_d;
    end
    assign buf_din      = {last_inflight_q, bus.mem_rdata};
    assign bus.out_last = buf_head[DATA_WIDTH];
`else
    assign buf_din = bus.mem_rdata;
`endif

    spram_rd_buf #(.WIDTH(BUF_WIDTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (buf_din),
        .pop   (pop),
        .count (buf_count),
        .head  (buf_head)
    );

    assign bus.cmd_ready = rst_n && (state_q == RD_IDLE);
    assign bus.mem_req   = req;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = buf_head[DATA_WIDTH-1:0];
    assign bus.done      = done_q;
endmodule

// File: tb/tb_spram_stream_reader.sv
// Bench for spram_stream_reader: directed scenarios plus random jobs against a queue-based model.
module tb_spram_stream_reader;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spram_stream_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    spram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    logic [DW-1:0] ram [DEPTH];
    int  checks = 0, errors = 0, cyc = 0;
    int  gnt_mode = 0, ready_mode = 0;
    beat_t exp_q[$];
    bit  job_active = 0, done_pending = 0, done_seen = 0;
    int  job_base = 0, job_len = 0, job_issued = 0, outstanding = 0;
    bit  prev_out_stall = 0, prev_req_stall = 0, prev_last = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] beat_log[$];
    int  beat_cyc[$], addr_log[$];
    int  acc_cyc = 0, done_cyc = 0, req_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM: data for an issued read appears the following cycle.
    always @(posedge clk) if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= ram[bus.mem_addr];

    // Grant and sink-ready patterns, changed just after each rising edge.
    initial begin
        bit phase = 1'b0;
        bus.mem_gnt   = 1'b1;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase = ~phase;
            case (gnt_mode)
                0:       bus.mem_gnt = 1'b1;
                1:       bus.mem_gnt = phase;
                default: bus.mem_gnt = ($urandom_range(0, 3) != 0);
            endcase
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
            job_active     = 0;
            done_pending   = 0;
            outstanding    = 0;
            prev_out_stall = 0;
            prev_req_stall = 0;
        end else begin
            check("done", bus.done, done_pending);
            if (bus.done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            done_pending = 0;
            check("cmd_ready", bus.cmd_ready, !job_active);
            if (prev_out_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
`ifdef SPRAM_RD_LAST_EN
                check("stall_last", bus.out_last, prev_last);
`endif
            end
            if (prev_req_stall) begin
                check("hold_req", bus.mem_req, 1);
                check("hold_addr", bus.mem_addr, prev_addr);
            end
            if (bus.mem_req) begin
                req_cycles++;
                check("req_allowed", job_active && (job_issued < job_len), 1);
                check("mem_addr", bus.mem_addr, (job_base + job_issued) % DEPTH);
                if (bus.mem_gnt) begin
                    job_issued++;
                    outstanding++;
                    addr_log.push_back(int'(bus.mem_addr));
                end
            end
            prev_req_stall = bus.mem_req && !bus.mem_gnt;
            prev_addr      = bus.mem_addr;
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
`ifdef SPRAM_RD_LAST_EN
                    check("out_last", bus.out_last, e.last);
`endif
                    beat_log.push_back(bus.out_data);
                    beat_cyc.push_back(cyc);
                    outstanding--;
                    if (exp_q.size() == 0) begin
                        job_active   = 0;
                        done_pending = 1;
                    end
                end
            end
            prev_out_stall = bus.out_valid && !bus.out_ready;
            prev_data      = bus.out_data;
`ifdef SPRAM_RD_LAST_EN
            prev_last      = bus.out_last;
`endif
            check("credit", outstanding <= 2, 1);
            if (bus.cmd_valid && bus.cmd_ready) begin
                int n;
                acc_cyc    = cyc;
                n          = (int'(bus.cmd_len) > DEPTH) ? DEPTH : int'(bus.cmd_len);
                job_base   = int'(bus.cmd_base);
                job_len    = n;
                job_issued = 0;
                if (n == 0) begin
                    done_pending = 1;
                end else begin
                    job_active = 1;
                    for (int i = 0; i < n; i++) begin
                        e.data = ram[(job_base + i) % DEPTH];
                        e.last = (i == n - 1);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        beat_log.delete();
        beat_cyc.delete();
        addr_log.delete();
        done_seen  = 0;
        req_cycles = 0;
    endtask

    task automatic start_job(input int base, input int len);
        bit acc = 0;
        clear_logs();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = AW'(base);
        bus.cmd_len   = LW'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accept", acc, 1);
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done_seen; i++) wait_neg();
        check("job_done", done_seen, 1);
        wait_neg();
        check("idle_empty", bus.out_valid, 0);
    endtask

    task automatic run_job(input int base, input int len, input int bound);
        start_job(base, len);
        wait_done(bound);
    endtask

    initial begin
        logic [DW-1:0] t1_exp [4];
        logic [DW-1:0] t2_exp [5];
        int            t2_addr [5];
        bit            ok;
        t1_exp  = '{8'h13, 8'h14, 8'h15, 8'h16};
        t2_exp  = '{8'h1E, 8'h1F, 8'h10, 8'h11, 8'h12};
        t2_addr = '{14, 15, 0, 1, 2};
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 8'h10);

        #12;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_neg();
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // Back-to-back beats with first-beat latency and done timing pinned.
        run_job(3, 4, 60);
        check("t1_count", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_data", beat_log[i], t1_exp[i]);
                check("t1_consecutive", beat_cyc[i] - beat_cyc[0], i);
            end
            check("t1_first_latency", beat_cyc[0] - acc_cyc, 3);
            check("t1_done_after_last", done_cyc - beat_cyc[3], 1);
        end

        // Address wrap past DEPTH-1.
        run_job(14, 5, 60);
        check("t2_count", beat_log.size(), 5);
        check("t2_addr_count", addr_log.size(), 5);
        if (beat_log.size() == 5 && addr_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t2_data", beat_log[i], t2_exp[i]);
                check("t2_addr", addr_log[i], t2_addr[i]);
            end
        end

        // Sink back-pressure: reads stop with both buffer slots full.
        start_job(0, 6);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            wait_neg();
            ok = (beat_log.size() >= 1);
        end
        check("t3_first_beat", ok, 1);
        ready_mode = 1;
        for (int i = 0; i < 5; i++) wait_neg();
        check("t3_req_stopped", bus.mem_req, 0);
        check("t3_outstanding", outstanding, 2);
        check("t3_valid_held", bus.out_valid, 1);
        ready_mode = 0;
        wait_done(60);
        check("t3_count", beat_log.size(), 6);
        if (beat_log.size() == 6) check("t3_last_data", beat_log[5], 8'h15);

        // Alternating grant.
        gnt_mode = 1;
        run_job(7, 4, 60);
        gnt_mode = 0;
        check("t4_count", beat_log.size(), 4);
        check("t4_addr_count", addr_log.size(), 4);
        if (beat_log.size() == 4 && addr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t4_data", beat_log[i], 8'h17 + i);
                check("t4_addr", addr_log[i], 7 + i);
            end
        end

        // Empty job and over-long job.
        run_job(5, 0, 10);
        check("t5_no_req", req_cycles, 0);
        check("t5_done_latency", done_cyc - acc_cyc, 1);
        check("t5_no_beats", beat_log.size(), 0);
        run_job(9, 20, 80);
        check("t5_clamped_count", beat_log.size(), 16);
        if (beat_log.size() == 16) begin
            check("t5_first", beat_log[0], 8'h19);
            check("t5_last", beat_log[15], 8'h18);
        end

        // Reset in the middle of a job.
        start_job(0, 8);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            wait_neg();
            ok = (beat_log.size() >= 2);
        end
        check("t6_two_beats", ok, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid_cleared", bus.out_valid, 0);
        check("t6_req_cleared", bus.mem_req, 0);
        check("t6_cmd_ready_low", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) wait_neg();
        check("t6_no_done", done_seen, 0);
        check("t6_valid_idle", bus.out_valid, 0);
        run_job(2, 3, 60);
        check("t6_new_job_count", beat_log.size(), 3);

        // Random jobs with random RAM contents, grant and sink stalls.
        gnt_mode   = 2;
        ready_mode = 2;
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom_range(0, 255));
            run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), 400);
        end
        gnt_mode   = 0;
        ready_mode = 0;
        wait_neg();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
